batch_sample_sched: RTL and testbench

Address and phase scheduler for the batch fixed-point filter's sample and result memories. Drives one write port and three read ports of the triple-read sample RAM, plus the forward and backward result RAMs. The sample RAM is treated as four rotating sectors of downsampled words. The block rotates the reader roles (lookahead, backward, forward) at each batch boundary and reports when outputs become valid.

---
 rtl/batch_sample_sched.sv | 194 +++++++++++++++++++
 tb/tb_batch_sample_sched.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/batch_sample_sched.sv
// batch_sample_sched
// Address and phase scheduler for the batch fixed-point filter.
// The sample RAM is split into four rotating sectors of DSD words each.
// One sector is written while the three older ones are read:
//   lookahead (newest complete sector, read backwards),
//   backward recursion (next older, read backwards),
//   forward recursion (oldest, read forwards).
// The result RAMs are double-buffered by a single bank bit.
// All addresses are pure decodes of the pointer registers, so the
// addresses for a word are present in the same cycle as its in_valid.

module batch_sample_sched #(
    parameter  int depth  = 220,
    parameter  int DSR    = 12,
    localparam int DSD    = (depth + DSR - 1) / DSR,
    localparam int ADDR_W = $clog2(4 * DSD),
    localparam int RES_W  = $clog2(2 * DSD)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              flush,
    output logic              sampleWrite,
    output logic [ADDR_W-1:0] sampleAddrIn,
    output logic [ADDR_W-1:0] sampleAddrOut1,
    output logic [ADDR_W-1:0] sampleAddrOut2,
    output logic [ADDR_W-1:0] sampleAddrOut3,
    output logic              resWriteB,
    output logic              resWriteF,
    output logic [RES_W-1:0]  resAddrInB,
    output logic [RES_W-1:0]  resAddrInF,
    output logic [RES_W-1:0]  resAddrOutB,
    output logic [RES_W-1:0]  resAddrOutF,
    output logic              batchStart,
    output logic              valid
);

    // Width of the in-sector word counter (at least one bit).
    localparam int CNT_W = (DSD > 1) ? $clog2(DSD) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DSD - 1);
    localparam logic [ADDR_W-1:0] DSD_ADDR  = ADDR_W'(DSD);
    localparam logic [RES_W-1:0]  DSD_RES   = RES_W'(DSD);
    localparam logic [2:0]        SEC_FULL  = 3'd4;
    localparam logic [2:0]        SEC_CALC  = 3'd3;

    // Warm-up phases: FILL until three sectors are stored, CALC while the
    // first backward pass runs, RUN once the filter output is meaningful.
    typedef enum logic [1:0] {
        FILL = 2'd0,
        CALC = 2'd1,
        RUN  = 2'd2
    } phase_t;

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_wrSec;
    logic             r_bank;
    phase_t           r_phase;
    logic [2:0]       r_secDone;
    logic             r_valid;
    logic             r_batchStart;

    logic [CNT_W-1:0] w_cntNext;
    logic [1:0]       w_wrSecNext;
    logic             w_bankNext;
    phase_t           w_phaseNext;
    logic [2:0]       w_secDoneNext;

    logic             w_advance;
    logic             w_wrap;

    logic [1:0]        w_secLook;
    logic [1:0]        w_secBack;
    logic [1:0]        w_secFwd;
    logic [ADDR_W-1:0] w_cntUp;
    logic [ADDR_W-1:0] w_cntDown;
    logic [RES_W-1:0]  w_resCntUp;
    logic [RES_W-1:0]  w_resCntDown;
    logic [RES_W-1:0]  w_resBaseWr;
    logic [RES_W-1:0]  w_resBaseRd;

    // Base address of a sector inside the sample RAM.
    function automatic logic [ADDR_W-1:0] secBase(input logic [1:0] sec);
        return ADDR_W'(sec) * DSD_ADDR;
    endfunction

    // A new word is accepted only when no flush is pending; the sector
    // wraps on the last word of the current sector.
    assign w_advance = in_valid & ~flush;
    assign w_wrap    = w_advance & (r_cnt == CNT_LAST);

    // Pointer next-state: flush clears everything, an accepted word
    // steps the counter and rolls sector, bank and completion count at wrap.
    always_comb begin
        w_cntNext     = r_cnt;
        w_wrSecNext   = r_wrSec;
        w_bankNext    = r_bank;
        w_secDoneNext = r_secDone;
        if (flush) begin
            w_cntNext     = '0;
            w_wrSecNext   = '0;
            w_bankNext    = 1'b0;
            w_secDoneNext = '0;
        end else if (w_advance) begin
            if (w_wrap) begin
                w_cntNext   = '0;
                w_wrSecNext = r_wrSec + 2'd1;
                w_bankNext  = ~r_bank;
                if (r_secDone != SEC_FULL) begin
                    w_secDoneNext = r_secDone + 3'd1;
                end
            end else begin
                w_cntNext = r_cnt + CNT_W'(1);
            end
        end
    end

    // Phase next-state follows the completion count on the same edge it
    // changes, so the phase is already updated for the following word.
    always_comb begin
        w_phaseNext = r_phase;
        if (flush) begin
            w_phaseNext = FILL;
        end else begin
            case (r_phase)
                FILL: if (w_secDoneNext >= SEC_CALC) w_phaseNext = CALC;
                CALC: if (w_secDoneNext == SEC_FULL) w_phaseNext = RUN;
                RUN:  w_phaseNext = RUN;
                default: w_phaseNext = FILL;
            endcase
        end
    end

    // Pointer and phase registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_wrSec   <= '0;
            r_bank    <= 1'b0;
            r_secDone <= '0;
            r_phase   <= FILL;
        end else begin
            r_cnt     <= w_cntNext;
            r_wrSec   <= w_wrSecNext;
            r_bank    <= w_bankNext;
            r_secDone <= w_secDoneNext;
            r_phase   <= w_phaseNext;
        end
    end

    // Registered status: valid trails RUN by one cycle, batchStart marks
    // the cycle right after a sector wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid      <= 1'b0;
            r_batchStart <= 1'b0;
        end else begin
            r_valid      <= ~flush & (r_phase == RUN);
            r_batchStart <= w_wrap;
        end
    end

    // Reader sectors trail the writer by one, two and three sectors;
    // the two-bit arithmetic gives the modulo-4 rotation for free.
    assign w_secLook = r_wrSec - 2'd1;
    assign w_secBack = r_wrSec - 2'd2;
    assign w_secFwd  = r_wrSec - 2'd3;

    assign w_cntUp      = ADDR_W'(r_cnt);
    assign w_cntDown    = ADDR_W'(CNT_LAST - r_cnt);
    assign w_resCntUp   = RES_W'(r_cnt);
    assign w_resCntDown = RES_W'(CNT_LAST - r_cnt);

    // Writer uses the current bank; readers use the other one.
    assign w_resBaseWr = r_bank ? DSD_RES : '0;
    assign w_resBaseRd = r_bank ? '0 : DSD_RES;

    assign sampleWrite    = w_advance;
    assign sampleAddrIn   = secBase(r_wrSec)   + w_cntUp;
    assign sampleAddrOut1 = secBase(w_secLook) + w_cntDown;
    assign sampleAddrOut2 = secBase(w_secBack) + w_cntDown;
    assign sampleAddrOut3 = secBase(w_secFwd)  + w_cntUp;

    assign resWriteB   = w_advance & (r_phase != FILL);
    assign resWriteF   = w_advance & (r_phase != FILL);
    assign resAddrInB  = w_resBaseWr + w_resCntDown;
    assign resAddrInF  = w_resBaseWr + w_resCntUp;
    assign resAddrOutB = w_resBaseRd + w_resCntUp;
    assign resAddrOutF = w_resBaseRd + w_resCntUp;

    assign batchStart = r_batchStart;
    assign valid      = r_valid;

endmodule

// File: tb/tb_batch_sample_sched.sv
// tb_batch_sample_sched
// Directed self-checking bench for batch_sample_sched with the default
// depth=220, DSR=12 configuration (DSD=19, 76-word sample RAM).

module tb_batch_sample_sched;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       flush;
    logic       sampleWrite;
    logic [6:0] sampleAddrIn;
    logic [6:0] sampleAddrOut1;
    logic [6:0] sampleAddrOut2;
    logic [6:0] sampleAddrOut3;
    logic       resWriteB;
    logic       resWriteF;
    logic [5:0] resAddrInB;
    logic [5:0] resAddrInF;
    logic [5:0] resAddrOutB;
    logic [5:0] resAddrOutF;
    logic       batchStart;
    logic       valid;

    int nChecks = 0;
    int nPass   = 0;

    // Reset values for DSD=19, in the order the observation arrays use.
    int    rstExp  [13] = '{0, 0, 75, 56, 19, 0, 0, 18, 0, 19, 19, 0, 0};
    string rstName [13] = '{"sampleWrite", "sampleAddrIn", "sampleAddrOut1",
                            "sampleAddrOut2", "sampleAddrOut3", "resWriteB",
                            "resWriteF", "resAddrInB", "resAddrInF",
                            "resAddrOutB", "resAddrOutF", "batchStart", "valid"};

    batch_sample_sched dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .flush          (flush),
        .sampleWrite    (sampleWrite),
        .sampleAddrIn   (sampleAddrIn),
        .sampleAddrOut1 (sampleAddrOut1),
        .sampleAddrOut2 (sampleAddrOut2),
        .sampleAddrOut3 (sampleAddrOut3),
        .resWriteB      (resWriteB),
        .resWriteF      (resWriteF),
        .resAddrInB     (resAddrInB),
        .resAddrInF     (resAddrInF),
        .resAddrOutB    (resAddrOutB),
        .resAddrOutF    (resAddrOutF),
        .batchStart     (batchStart),
        .valid          (valid)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference addresses for the n-th accepted word since reset (DSD=19).
    function automatic int expIn(input int n);
        return ((n / 19) % 4) * 19 + (n % 19);
    endfunction
    function automatic int expOut1(input int n);
        return (((n / 19) + 3) % 4) * 19 + 18 - (n % 19);
    endfunction
    function automatic int expOut2(input int n);
        return (((n / 19) + 2) % 4) * 19 + 18 - (n % 19);
    endfunction
    function automatic int expOut3(input int n);
        return (((n / 19) + 1) % 4) * 19 + (n % 19);
    endfunction
    function automatic int expResInB(input int n);
        return ((n / 19) % 2) * 19 + 18 - (n % 19);
    endfunction
    function automatic int expResInF(input int n);
        return ((n / 19) % 2) * 19 + (n % 19);
    endfunction
    function automatic int expResOut(input int n);
        return (1 - ((n / 19) % 2)) * 19 + (n % 19);
    endfunction

    // Hold reset for a cycle and release it away from the clock edge.
    // Leaves the bench one time unit after a rising edge.
    task automatic doReset();
        in_valid = 1'b0;
        flush    = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    // Accept one word without checking anything (used to reach a state).
    task automatic applyStimulus(input int count);
        for (int i = 0; i < count; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        int obs [13];
        doReset();
        for (int pass = 0; pass < 2; pass++) begin
            obs = '{int'(sampleWrite), int'(sampleAddrIn), int'(sampleAddrOut1),
                    int'(sampleAddrOut2), int'(sampleAddrOut3), int'(resWriteB),
                    int'(resWriteF), int'(resAddrInB), int'(resAddrInF),
                    int'(resAddrOutB), int'(resAddrOutF), int'(batchStart), int'(valid)};
            for (int i = 0; i < 13; i++) begin
                nChecks++;
                if (obs[i] !== rstExp[i])
                    $display("[TB] FAIL reset_%s: got %0d expected %0d", rstName[i], obs[i], rstExp[i]);
                else
                    nPass++;
            end
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    // Expects a freshly reset DUT; leaves it one cycle after the first wrap.
    task automatic test_first_sector();
        for (int k = 0; k < 19; k++) begin
            in_valid = 1'b1;
            #1;
            nChecks++;
            if (int'(sampleAddrIn) !== k)
                $display("[TB] FAIL first_addrIn[%0d]: got %0d expected %0d", k, sampleAddrIn, k);
            else nPass++;
            nChecks++;
            if (int'(sampleAddrOut3) !== 19 + k)
                $display("[TB] FAIL first_addrOut3[%0d]: got %0d expected %0d", k, sampleAddrOut3, 19 + k);
            else nPass++;
            nChecks++;
            if (int'(sampleAddrOut1) !== 75 - k)
                $display("[TB] FAIL first_addrOut1[%0d]: got %0d expected %0d", k, sampleAddrOut1, 75 - k);
            else nPass++;
            nChecks++;
            if (int'(sampleAddrOut2) !== 56 - k)
                $display("[TB] FAIL first_addrOut2[%0d]: got %0d expected %0d", k, sampleAddrOut2, 56 - k);
            else nPass++;
            nChecks++;
            if (sampleWrite !== 1'b1 || resWriteB !== 1'b0 || resWriteF !== 1'b0)
                $display("[TB] FAIL first_strobes[%0d]: got sw=%b rb=%b rf=%b expected 1 0 0",
                         k, sampleWrite, resWriteB, resWriteF);
            else nPass++;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        #1;
        nChecks++;
        if (batchStart !== 1'b1)
            $display("[TB] FAIL first_batchStart: got %b expected 1", batchStart);
        else nPass++;
        nChecks++;
        if (sampleAddrIn !== 7'd19)
            $display("[TB] FAIL first_wrSec1: sampleAddrIn got %0d expected 19", sampleAddrIn);
        else nPass++;
        nChecks++;
        if (resAddrInF !== 6'd19 || resAddrInB !== 6'd37 || resAddrOutB !== 6'd0)
            $display("[TB] FAIL first_bank1: got inF=%0d inB=%0d outB=%0d expected 19 37 0",
                     resAddrInF, resAddrInB, resAddrOutB);
        else nPass++;
        nChecks++;
        if (sampleWrite !== 1'b0)
            $display("[TB] FAIL first_idleWrite: got %b expected 0", sampleWrite);
        else nPass++;
        @(posedge clk); #1;
        nChecks++;
        if (batchStart !== 1'b0)
            $display("[TB] FAIL first_batchStartPulse: got %b expected 0", batchStart);
        else nPass++;
    endtask

    task automatic test_warmup();
        logic expRes;
        doReset();
        for (int k = 0; k < 76; k++) begin
            in_valid = 1'b1;
            #1;
            expRes = (k >= 57);
            nChecks++;
            if (resWriteB !== expRes || resWriteF !== expRes)
                $display("[TB] FAIL warmup_resWrite[%0d]: got b=%b f=%b expected %b",
                         k, resWriteB, resWriteF, expRes);
            else nPass++;
            if (k == 75) begin
                nChecks++;
                if (valid !== 1'b0)
                    $display("[TB] FAIL warmup_validEarly: got %b expected 0", valid);
                else nPass++;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        @(posedge clk); #1;
        nChecks++;
        if (valid !== 1'b1)
            $display("[TB] FAIL warmup_valid: got %b expected 1", valid);
        else nPass++;
        in_valid = 1'b1;
        #1;
        nChecks++;
        if (sampleAddrIn !== 7'd0 || sampleAddrOut3 !== 7'd19)
            $display("[TB] FAIL warmup_wrap77: got in=%0d out3=%0d expected 0 19",
                     sampleAddrIn, sampleAddrOut3);
        else nPass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_gaps();
        int gaps;
        doReset();
        for (int n = 0; n < 80; n++) begin
            gaps = int'($urandom_range(3, 0));
            for (int g = 0; g < gaps; g++) begin
                in_valid = 1'b0;
                #1;
                nChecks++;
                if (sampleWrite !== 1'b0 || resWriteB !== 1'b0 || resWriteF !== 1'b0)
                    $display("[TB] FAIL gaps_idleStrobe[%0d]: got sw=%b rb=%b rf=%b expected 0 0 0",
                             n, sampleWrite, resWriteB, resWriteF);
                else nPass++;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            #1;
            nChecks++;
            if (int'(sampleAddrIn) !== expIn(n) || int'(sampleAddrOut1) !== expOut1(n) ||
                int'(sampleAddrOut2) !== expOut2(n) || int'(sampleAddrOut3) !== expOut3(n))
                $display("[TB] FAIL gaps_sampleAddr[%0d]: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                         n, sampleAddrIn, sampleAddrOut1, sampleAddrOut2, sampleAddrOut3,
                         expIn(n), expOut1(n), expOut2(n), expOut3(n));
            else nPass++;
            nChecks++;
            if (int'(resAddrInB) !== expResInB(n) || int'(resAddrInF) !== expResInF(n) ||
                int'(resAddrOutB) !== expResOut(n) || int'(resAddrOutF) !== expResOut(n))
                $display("[TB] FAIL gaps_resAddr[%0d]: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                         n, resAddrInB, resAddrInF, resAddrOutB, resAddrOutF,
                         expResInB(n), expResInF(n), expResOut(n), expResOut(n));
            else nPass++;
            nChecks++;
            if (resWriteB !== (n >= 57) || sampleWrite !== 1'b1)
                $display("[TB] FAIL gaps_strobe[%0d]: got sw=%b rb=%b expected 1 %b",
                         n, sampleWrite, resWriteB, (n >= 57));
            else nPass++;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic test_flush();
        int obs [13];
        doReset();
        applyStimulus(39);
        in_valid = 1'b1;
        flush    = 1'b1;
        #1;
        nChecks++;
        if (sampleWrite !== 1'b0 || resWriteB !== 1'b0 || resWriteF !== 1'b0)
            $display("[TB] FAIL flush_noWrite: got sw=%b rb=%b rf=%b expected 0 0 0",
                     sampleWrite, resWriteB, resWriteF);
        else nPass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        obs = '{int'(sampleWrite), int'(sampleAddrIn), int'(sampleAddrOut1),
                int'(sampleAddrOut2), int'(sampleAddrOut3), int'(resWriteB),
                int'(resWriteF), int'(resAddrInB), int'(resAddrInF),
                int'(resAddrOutB), int'(resAddrOutF), int'(batchStart), int'(valid)};
        for (int i = 0; i < 13; i++) begin
            nChecks++;
            if (obs[i] !== rstExp[i])
                $display("[TB] FAIL flush_%s: got %0d expected %0d", rstName[i], obs[i], rstExp[i]);
            else nPass++;
        end
        applyStimulus(80);
        @(posedge clk); #1;
        nChecks++;
        if (valid !== 1'b1)
            $display("[TB] FAIL flush_runValid: got %b expected 1", valid);
        else nPass++;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(posedge clk); #1;
        nChecks++;
        if (valid !== 1'b0 || sampleAddrIn !== 7'd0 || sampleAddrOut1 !== 7'd75)
            $display("[TB] FAIL flush_runDrop: got valid=%b in=%0d out1=%0d expected 0 0 75",
                     valid, sampleAddrIn, sampleAddrOut1);
        else nPass++;
    endtask

    task automatic test_async_reset();
        int obs [13];
        doReset();
        applyStimulus(89);
        nChecks++;
        if (valid !== 1'b1)
            $display("[TB] FAIL async_preValid: got %b expected 1", valid);
        else nPass++;
        in_valid = 1'b1;
        #1;
        nChecks++;
        if (int'(sampleAddrIn) !== expIn(89))
            $display("[TB] FAIL async_preAddr: got %0d expected %0d", sampleAddrIn, expIn(89));
        else nPass++;
        #2;
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        obs = '{int'(sampleWrite), int'(sampleAddrIn), int'(sampleAddrOut1),
                int'(sampleAddrOut2), int'(sampleAddrOut3), int'(resWriteB),
                int'(resWriteF), int'(resAddrInB), int'(resAddrInF),
                int'(resAddrOutB), int'(resAddrOutF), int'(batchStart), int'(valid)};
        for (int i = 0; i < 13; i++) begin
            nChecks++;
            if (obs[i] !== rstExp[i])
                $display("[TB] FAIL async_%s: got %0d expected %0d", rstName[i], obs[i], rstExp[i]);
            else nPass++;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        test_first_sector();
    endtask

    // Run every scenario in order, then report.
    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        test_reset();
        doReset();
        test_first_sector();
        test_warmup();
        test_gaps();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
